// File: rtl/meas_frame_tx.sv
// meas_frame_tx: captures NUM_CH (fx, gate) counter pairs on data_ready and
// streams them as one framed byte packet over the tx_en / tx_done handshake.
// Frame: HDR0, HDR1, NUM_CH, {fx[ch] MSB-first, gate[ch] MSB-first}..., [checksum]
// Optional feature macro: FRAME_CHECKSUM_EN (appends a mod-256 sum byte).
module meas_frame_tx #(
  parameter int         NUM_CH = 2,
  parameter int         CNT_W  = 32,
  parameter logic [7:0] HDR0   = 8'hA5,
  parameter logic [7:0] HDR1   = 8'h5A
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  input  logic                    data_ready,
  input  logic [NUM_CH*CNT_W-1:0] fx_cnt,
  input  logic [NUM_CH*CNT_W-1:0] gate_cnt,
  input  logic                    uart_tx_done,
  output logic                    uart_tx_en,
  output logic [7:0]              uart_tx_data,
  output logic                    busy,
  output logic [7:0]              drop_cnt
);

  localparam int BPC      = CNT_W / 8;          // bytes per counter
  localparam int DATA_LEN = NUM_CH * 2 * BPC;   // payload bytes
`ifdef FRAME_CHECKSUM_EN
  localparam int CSUM_LEN = 1;
`else
  localparam int CSUM_LEN = 0;
`endif
  localparam int FRAME_LEN = 3 + DATA_LEN + CSUM_LEN;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]              state_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [NUM_CH*CNT_W-1:0] fx_reg;
  logic [NUM_CH*CNT_W-1:0] gate_reg;
  logic [7:0]              frame_bytes [FRAME_LEN];
  logic [IDX_W-1:0]        next_idx;
  logic [7:0]              next_byte;
  logic                    last_done;
  logic                    accept;
  logic                    reject;

  // Fixed header bytes of every frame.
  assign frame_bytes[0] = HDR0;
  assign frame_bytes[1] = HDR1;
  assign frame_bytes[2] = 8'(NUM_CH);

  // Payload byte map: per channel the fx bytes MSB-first, then the gate bytes.
  generate
    for (genvar gi = 0; gi < DATA_LEN; gi++) begin : g_data
      localparam int CH   = gi / (2 * BPC);
      localparam int POS  = gi % (2 * BPC);
      localparam int OFS  = CH * CNT_W + (BPC - 1 - (POS % BPC)) * 8;
      if (POS < BPC) begin : g_fx
        assign frame_bytes[3 + gi] = fx_reg[OFS +: 8];
      end else begin : g_gate
        assign frame_bytes[3 + gi] = gate_reg[OFS +: 8];
      end
    end
  endgenerate

`ifdef FRAME_CHECKSUM_EN
  localparam logic [IDX_W-1:0] FIRST_SUM_IDX = IDX_W'(2);
  localparam logic [IDX_W-1:0] LAST_SUM_IDX  = IDX_W'(2 + DATA_LEN);
  logic [7:0] sum_reg;

  assign frame_bytes[FRAME_LEN-1] = sum_reg;

  // Running sum of NUM_CH byte and payload, folded in as each byte is sent.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sum_reg <= 8'h00;
    end else if (accept) begin
      sum_reg <= 8'h00;
    end else if (state_reg == SEND && idx_reg >= FIRST_SUM_IDX &&
                 idx_reg <= LAST_SUM_IDX) begin
      sum_reg <= sum_reg + uart_tx_data;
    end
  end
`endif

  assign next_idx  = idx_reg + IDX_W'(1);
  assign last_done = (state_reg == WAIT) && uart_tx_done && (idx_reg == LAST_IDX);
  // A new frame may start from IDLE or on the very edge the last byte finishes.
  assign accept    = data_ready && ((state_reg == IDLE) || last_done);
  assign reject    = data_ready && !accept;

  // Byte to present after the current one completes.
  always_comb begin
    next_byte = 8'h00;
    if (next_idx <= LAST_IDX) begin
      next_byte = frame_bytes[next_idx];
    end
  end

  // Frame sequencer: capture, present byte + one-cycle strobe, wait for done.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      fx_reg       <= '0;
      gate_reg     <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
      busy         <= 1'b0;
    end else begin
      uart_tx_en <= 1'b0;
      if (accept) begin
        fx_reg       <= fx_cnt;
        gate_reg     <= gate_cnt;
        idx_reg      <= '0;
        uart_tx_data <= HDR0;
        uart_tx_en   <= 1'b1;
        busy         <= 1'b1;
        state_reg    <= SEND;
      end else begin
        case (state_reg)
          SEND: state_reg <= WAIT;
          WAIT: begin
            if (uart_tx_done) begin
              if (idx_reg == LAST_IDX) begin
                busy      <= 1'b0;
                state_reg <= IDLE;
              end else begin
                idx_reg      <= next_idx;
                uart_tx_data <= next_byte;
                uart_tx_en   <= 1'b1;
                state_reg    <= SEND;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Saturating count of data_ready pulses that arrived while a frame was busy.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'h00;
    end else if (reject && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
